ascii_key_player: RTL and testbench
===================================

// Module: ascii_key_player
//
// PURPOSE
// Inverse of the key decoder: accepts ASCII key codes over a valid/ready handshake.
// Replays each code as a timed press on one of four key lines (a, b, c, d).
// A press is a hold window followed by a release gap. Drives key-decoder benches
// and keyboard-emulation paths from a code stream. Codes with no key mapping are
// rejected with an error pulse.
//
// PARAMETERS
// HOLD_CYCLES   4  cycles a key line stays high per press; legal range >= 1
// GAP_CYCLES    2  cycles all key lines stay low after a press; 0 allowed
// ACCEPT_LOWER  1  1: also map 0x61..0x64 ('a'..'d'); 0: lowercase codes are illegal
//
// PORTS
// clk         in   1  clock; all state changes on posedge
// rst         in   1  asynchronous, active-high reset
// code_in     in   8  ASCII code; sampled when code_valid && code_ready
// code_valid  in   1  producer has a code on code_in
// code_ready  out  1  block can accept a code this cycle
// key_a       out  1  key a pressed
// key_b       out  1  key b pressed
// key_c       out  1  key c pressed
// key_d       out  1  key d pressed
// busy        out  1  press or gap in progress
// err         out  1  one-cycle pulse: last accepted code was illegal
// err_code    out  8  last illegal code; held until the next illegal code
//
// BEHAVIOUR
// - Reset (async): state=IDLE, counter=0, key_*=0, busy=0, err=0, err_code=8'h00.
//   code_ready=0 while rst=1.
// - Code map:
//   0x41->key_a, 0x42->key_b, 0x43->key_c, 0x44->key_d.
//   0x61..0x64 map to the same keys when ACCEPT_LOWER=1. Every other code is illegal.
// - FSM states: IDLE, PRESS, GAP.
//   code_ready = (state==IDLE) && !rst, combinational.
//   busy = (state!=IDLE), registered.
// - Accept: code_valid && code_ready in cycle t.
//   - Legal code: latch key index; PRESS in cycles t+1..t+HOLD_CYCLES.
//   - PRESS then leads to GAP for cycles t+HOLD_CYCLES+1..t+HOLD_CYCLES+GAP_CYCLES.
//   - Then IDLE; code_ready=1 in cycle t+HOLD_CYCLES+GAP_CYCLES+1.
//   - GAP_CYCLES=0: PRESS goes straight to IDLE.
// - Illegal code: stay in IDLE; err=1 in cycle t+1 only; err_code=code_in from t+1.
//   code_ready stays 1, so back-to-back illegal codes each produce one err pulse.
// - Key outputs are registered:
//   - exactly one key_* high in every PRESS cycle;
//   - all key_* low in IDLE and GAP, so outputs are never multi-hot.
// - code_valid while code_ready=0: ignored, no capture. The producer must hold the code.
// - code_in changes while not accepted: no effect.
// - Counter width: $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1).
//   - Counter loads on each state entry and decrements to 1; the state changes on 1.
//   - No wrap-around.
// - rst asserted mid-PRESS or mid-GAP:
//   - key_* drop to 0 asynchronously; the in-flight press is discarded;
//   - the press does not resume after reset release.
// - Simultaneous rst and code_valid: reset wins; no accept.
//
// TESTING
// - Reset, then send 0x41 with HOLD=4, GAP=2, accepted at t -> key_a=1 in t+1..t+4.
//   All keys low in t+5..t+6; code_ready=1 at t+7.
// - Stream 0x42,0x43,0x44 with code_valid held -> each key high for exactly 4 cycles.
//   Presses are separated by 2 low cycles; no two keys are ever high together.
// - Send 0x5A, then 0x00 back-to-back -> err pulses at t+1 and t+2; err_code=0x00 at end.
//   All key lines stay 0 throughout.
// - ACCEPT_LOWER=1: send 0x63 -> key_c pulse.
//   ACCEPT_LOWER=0: send 0x63 -> err=1, err_code=0x63, no key.
// - Assert rst 2 cycles into a key_d press -> key_d=0 immediately, busy=0, code_ready=0.
//   After release, code_ready=1 and key_d stays low.
// - GAP_CYCLES=0, HOLD_CYCLES=1: send 0x41 -> key_a high 1 cycle.
//   code_ready=1 in the following cycle.

Source files
------------

// File: rtl/ascii_key_player.sv
// ascii_key_player: replays ASCII key codes as timed presses on four key lines
module ascii_key_player #(
    parameter int HOLD_CYCLES  = 4,
    parameter int GAP_CYCLES   = 2,
    parameter bit ACCEPT_LOWER = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    output logic       code_ready,
    output logic       key_a,
    output logic       key_b,
    output logic       key_c,
    output logic       key_d,
    output logic       busy,
    output logic       err,
    output logic [7:0] err_code
);
    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    keys, keys_n;
    logic          accept, legal, upper, lower;

    assign code_ready = (state == IDLE) && !rst;
    assign accept     = code_valid && code_ready;
    assign upper      = (code_in >= 8'h41) && (code_in <= 8'h44);
    assign lower      = (code_in >= 8'h61) && (code_in <= 8'h64);
    assign legal      = upper || (ACCEPT_LOWER && lower);
    assign {key_d, key_c, key_b, key_a} = keys;

    // next-state: the low two code bits (1,2,3,0) select key a..d in both cases
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        keys_n  = keys;
        case (state)
            IDLE: if (accept && legal) begin
                state_n = PRESS;
                cnt_n   = CW'(HOLD_CYCLES);
                keys_n  = 4'b0001 << (code_in[1:0] - 2'd1);
            end
            PRESS: if (cnt == CW'(1)) begin
                state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
                cnt_n   = CW'(GAP_CYCLES);
                keys_n  = '0;
            end else cnt_n = cnt - CW'(1);
            GAP: if (cnt == CW'(1)) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else cnt_n = cnt - CW'(1);
            default: state_n = IDLE;
        endcase
    end

    // state, key lines and status registers; reset drops everything at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            keys     <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
            err_code <= 8'h00;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            keys  <= keys_n;
            busy  <= (state_n != IDLE);
            err   <= accept && !legal;
            if (accept && !legal) err_code <= code_in;
        end
    end
endmodule

// File: tb/tb_ascii_key_player.sv
// tb_ascii_key_player: random and directed checks of the key player against a cycle-schedule model
module tb_ascii_key_player;
    localparam int H = 4;
    localparam int G = 2;

    logic       clk = 0, rst = 1;
    logic [7:0] code0 = 0, code1 = 0, code2 = 0;
    logic       valid0 = 0, valid1 = 0, valid2 = 0;
    logic       ready0, ready1, ready2, busy0, busy1, busy2, err0, err1, err2;
    logic [3:0] k0, k1, k2;
    logic [7:0] ec0, ec1, ec2;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    ascii_key_player #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .ACCEPT_LOWER(1'b1)) dut0 (
        .clk(clk), .rst(rst), .code_in(code0), .code_valid(valid0), .code_ready(ready0),
        .key_a(k0[0]), .key_b(k0[1]), .key_c(k0[2]), .key_d(k0[3]),
        .busy(busy0), .err(err0), .err_code(ec0));

    ascii_key_player #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .ACCEPT_LOWER(1'b0)) dut1 (
        .clk(clk), .rst(rst), .code_in(code1), .code_valid(valid1), .code_ready(ready1),
        .key_a(k1[0]), .key_b(k1[1]), .key_c(k1[2]), .key_d(k1[3]),
        .busy(busy1), .err(err1), .err_code(ec1));

    ascii_key_player #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .ACCEPT_LOWER(1'b1)) dut2 (
        .clk(clk), .rst(rst), .code_in(code2), .code_valid(valid2), .code_ready(ready2),
        .key_a(k2[0]), .key_b(k2[1]), .key_c(k2[2]), .key_d(k2[3]),
        .busy(busy2), .err(err2), .err_code(ec2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal_m(input logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h44) || (c >= 8'h61 && c <= 8'h64);
    endfunction

    function automatic int key_of(input logic [7:0] c);
        return (c >= 8'h61) ? int'(c) - 'h61 : int'(c) - 'h41;
    endfunction

    // model: each accepted code books absolute cycle windows for its press, gap and error pulse
    int n = 0, free_at = 0, pf = 0, pl = -1, kidx = 0, err_cyc = -1;
    logic [7:0] ec_exp = 0;
    logic [3:0] exp_keys;
    always @(negedge clk) begin
        n++;
        if (rst) begin
            chk("rst_ready", ready0, 0);
            chk("rst_keys", k0, 0);
            chk("rst_busy", busy0, 0);
            chk("rst_err", err0, 0);
            chk("rst_err_code", ec0, 0);
            free_at = 0; pf = 0; pl = -1; err_cyc = -1; ec_exp = 0;
        end else begin
            exp_keys = (n >= pf && n <= pl) ? (4'b0001 << kidx) : 4'h0;
            chk("m_ready", ready0, n >= free_at);
            chk("m_keys", k0, exp_keys);
            chk("m_busy", busy0, n < free_at);
            chk("m_err", err0, n == err_cyc);
            chk("m_err_code", ec0, ec_exp);
            if (valid0 && n >= free_at) begin
                if (legal_m(code0)) begin
                    pf = n + 1; pl = n + H; free_at = n + H + G + 1; kidx = key_of(code0);
                end else begin
                    err_cyc = n + 1; ec_exp = code0;
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic offer0(input logic [7:0] c);
        int i;
        nxt();
        valid0 = 1; code0 = c;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready0) break;
            nxt();
        end
        if (i == 40) chk("accept_timeout", 0, 1);
    endtask

    initial begin
        @(negedge clk);
        chk("lit_rst_ready", ready0, 0);
        chk("lit_rst_err_code", ec0, 8'h00);
        nxt();
        rst = 0; valid0 = 1; code0 = 8'h41;
        @(negedge clk);
        chk("lit_a_accept", ready0, 1);
        nxt();
        valid0 = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("lit_a_key", k0[0], k <= 4);
            chk("lit_a_others", k0[3:1], 0);
            chk("lit_a_ready", ready0, k == 7);
            if (k < 7) nxt();
        end
        nxt();
        valid1 = 1; code1 = 8'h63;
        @(negedge clk);
        chk("lit_nl_accept", ready1, 1);
        nxt();
        valid1 = 0;
        @(negedge clk);
        chk("lit_nl_err", err1, 1);
        chk("lit_nl_err_code", ec1, 8'h63);
        chk("lit_nl_keys", k1, 0);
        nxt();
        @(negedge clk);
        chk("lit_nl_err_end", err1, 0);
        chk("lit_nl_keys_end", k1, 0);
        nxt();
        valid2 = 1; code2 = 8'h41;
        @(negedge clk);
        chk("lit_h1_accept", ready2, 1);
        nxt();
        valid2 = 0;
        @(negedge clk);
        chk("lit_h1_key", k2, 4'b0001);
        chk("lit_h1_ready_low", ready2, 0);
        nxt();
        @(negedge clk);
        chk("lit_h1_key_off", k2, 0);
        chk("lit_h1_ready", ready2, 1);
        chk("lit_h1_busy", busy2, 0);
        offer0(8'h42);
        offer0(8'h43);
        offer0(8'h44);
        nxt();
        valid0 = 0;
        offer0(8'h5A);
        nxt();
        code0 = 8'h00;
        @(negedge clk);
        chk("lit_e1_err", err0, 1);
        chk("lit_e1_code", ec0, 8'h5A);
        nxt();
        valid0 = 0;
        @(negedge clk);
        chk("lit_e2_err", err0, 1);
        chk("lit_e2_code", ec0, 8'h00);
        nxt();
        @(negedge clk);
        chk("lit_e3_err", err0, 0);
        chk("lit_e3_code", ec0, 8'h00);
        chk("lit_e3_keys", k0, 0);
        offer0(8'h63);
        nxt();
        valid0 = 0;
        @(negedge clk);
        chk("lit_lc_key", k0, 4'b0100);
        offer0(8'h44);
        nxt();
        valid0 = 0;
        @(negedge clk);
        chk("lit_d_key", k0[3], 1);
        nxt();
        nxt();
        rst = 1;
        #1;
        chk("lit_rd_key", k0[3], 0);
        chk("lit_rd_busy", busy0, 0);
        chk("lit_rd_ready", ready0, 0);
        nxt();
        rst = 0;
        @(negedge clk);
        chk("lit_rd_ready_after", ready0, 1);
        for (int k = 0; k < 6; k++) begin
            nxt();
            @(negedge clk);
            chk("lit_rd_key_stays", k0[3], 0);
        end
        for (int i = 0; i < 1500; i++) begin
            int r;
            nxt();
            rst = ($urandom_range(0, 99) == 0);
            valid0 = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 9);
            if (r < 5) code0 = 8'h41 + 8'($urandom_range(0, 3));
            else if (r < 7) code0 = 8'h61 + 8'($urandom_range(0, 3));
            else code0 = 8'($urandom);
        end
        nxt();
        rst = 0; valid0 = 0;
        repeat (10) nxt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
